// File: rtl/insn_encoder.sv
// RV32I field-to-word encoder: range-checks decoded fields, packs them into
// 32-bit instructions and streams them to instruction memory at consecutive addresses.
module insn_encoder #(
    parameter int                DWIDTH      = 32,
    parameter int                AWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = 32'h0100_0000,
    parameter int                DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        fmt_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [31:0]       imm_i,
    input  logic              last_i,
    output logic              mem_wren_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [15:0]       count_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

    function automatic logic [31:0] encode_word(
        input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] w;
        w = 32'd0;
        case (fmt)
            3'd0: w = {f7, rs2, rs1, f3, rd, op};
            3'd1: begin
                if (is_shift(f3)) begin
                    w = {f7, imm[4:0], rs1, f3, rd, op};
                end else begin
                    w = {imm[11:0], rs1, f3, rd, op};
                end
            end
            3'd2: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            3'd3: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            3'd4: w = {imm[31:12], rd, op};
            3'd5: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Field legality only; depth overflow is judged against the live counters.
    function automatic logic [1:0] check_fields(
        input logic [2:0] fmt, input logic [2:0] f3, input logic [31:0] imm);
        logic signed [31:0] s;
        logic               bad;
        s   = $signed(imm);
        bad = 1'b0;
        case (fmt)
            3'd0: bad = 1'b0;
            3'd1: begin
                if (is_shift(f3)) begin
                    bad = (s < 32'sd0) || (s > 32'sd31);
                end else begin
                    bad = (s < -32'sd2048) || (s > 32'sd2047);
                end
            end
            3'd2: bad = (s < -32'sd2048) || (s > 32'sd2047);
            3'd3: bad = (s < -32'sd4096) || (s > 32'sd4094) || imm[0];
            3'd4: bad = (imm[11:0] != 12'd0);
            3'd5: bad = (s < -32'sd1048576) || (s > 32'sd1048574) || imm[0];
            default: bad = 1'b0;
        endcase
        if (fmt > 3'd5) begin
            return 2'd2;
        end else begin
            return bad ? 2'd1 : 2'd0;
        end
    endfunction

    state_t            state_q, state_d;
    logic              o_valid_q, o_valid_d;
    logic              o_last_q, o_last_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic [15:0]       count_q, count_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              req_ready_s, accept_s, mem_acc_s, depth_full_s;
    logic [1:0]        chk_code_s;
    logic [31:0]       enc_word_s;

    assign req_ready_s  = (state_q == S_RUN) && (!o_valid_q || mem_ready_i);
    assign accept_s     = req_valid_i && req_ready_s;
    assign mem_acc_s    = o_valid_q && mem_ready_i;
    assign depth_full_s = (({1'b0, count_q} + {16'd0, o_valid_q}) == DEPTH_L);
    assign chk_code_s   = check_fields(fmt_i, funct3_i, imm_i);
    assign enc_word_s   = encode_word(fmt_i, opcode_i, funct3_i, funct7_i,
                                      rd_i, rs1_i, rs2_i, imm_i);

    // Next-state: drain of the output register, request acceptance and FSM moves.
    always_comb begin
        state_d    = state_q;
        o_valid_d  = o_valid_q;
        o_last_d   = o_last_q;
        addr_d     = addr_q;
        data_d     = data_q;
        count_d    = count_q;
        err_code_d = err_code_q;

        if (mem_acc_s) begin
            o_valid_d = 1'b0;
            addr_d    = addr_q + AWIDTH'(32'd4);
            count_d   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        end else begin
            o_valid_d = o_valid_q;
        end

        case (state_q)
            S_RUN: begin
                if (mem_acc_s && o_last_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
                if (accept_s) begin
                    if (chk_code_s != 2'd0) begin
                        state_d    = S_ERR;
                        err_code_d = chk_code_s;
                    end else if (depth_full_s) begin
                        state_d    = S_ERR;
                        err_code_d = 2'd3;
                    end else begin
                        o_valid_d = 1'b1;
                        o_last_d  = last_i;
                        data_d    = DWIDTH'(enc_word_s);
                    end
                end else begin
                    o_last_d = o_last_q;
                end
            end
            S_IDLE, S_DONE, S_ERR: begin
                // Restart drops any word still waiting to drain from an error stop.
                if (start_i) begin
                    state_d    = S_RUN;
                    o_valid_d  = 1'b0;
                    o_last_d   = 1'b0;
                    addr_d     = BASE_ADDR;
                    count_d    = 16'd0;
                    err_code_d = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output-register update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            o_valid_q  <= 1'b0;
            o_last_q   <= 1'b0;
            addr_q     <= BASE_ADDR;
            data_q     <= '0;
            count_q    <= 16'd0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            o_valid_q  <= o_valid_d;
            o_last_q   <= o_last_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            count_q    <= count_d;
            err_code_q <= err_code_d;
        end
    end

    assign req_ready_o = req_ready_s;
    assign mem_wren_o  = o_valid_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;
    assign busy_o      = (state_q == S_RUN);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = (state_q == S_ERR);
    assign err_code_o  = err_code_q;
    assign count_o     = count_q;
endmodule

// File: tb/tb_insn_encoder.sv
// Self-checking bench for insn_encoder: directed program, error/restart, backpressure,
// depth overflow and async reset, plus randomized traffic against a behavioural model.
module tb_insn_encoder;
    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 1024;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_DONE = 2, ST_ERR = 3;

    logic        clk = 1'b0, reset = 1'b0;
    logic        start_i = 1'b0, req_valid_i = 1'b0, last_i = 1'b0, mem_ready_i = 1'b0;
    logic [2:0]  fmt_i = 3'd0, funct3_i = 3'd0;
    logic [6:0]  opcode_i = 7'd0, funct7_i = 7'd0;
    logic [4:0]  rd_i = 5'd0, rs1_i = 5'd0, rs2_i = 5'd0;
    logic [31:0] imm_i = 32'd0;
    logic        req_ready_o, mem_wren_o, busy_o, done_o, err_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [1:0]  err_code_o;
    logic [15:0] count_o;

    always #5 clk = ~clk;

    insn_encoder dut (
        .clk(clk), .reset(reset), .start_i(start_i), .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o), .fmt_i(fmt_i), .opcode_i(opcode_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .rd_i(rd_i), .rs1_i(rs1_i),
        .rs2_i(rs2_i), .imm_i(imm_i), .last_i(last_i), .mem_wren_o(mem_wren_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
        .count_o(count_o)
    );

    typedef struct { logic [31:0] w; bit last; } pw_t;
    pw_t         pq[$];
    int          m_st, m_count, m_code;
    logic [31:0] m_addr;
    int          n_chk = 0, n_pass = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endfunction

    function automatic logic [31:0] ref_encode(input int unsigned fmt, op, f3, f7, rd, rs1, rs2, u);
        int unsigned base;
        base = op | (f3 << 12) | (rs1 << 15);
        case (fmt)
            0: return base | (rd << 7) | (rs2 << 20) | (f7 << 25);
            1: if (f3 == 1 || f3 == 5) return base | (rd << 7) | ((u & 31) << 20) | (f7 << 25);
               else return base | (rd << 7) | ((u & 32'hFFF) << 20);
            2: return base | ((u & 31) << 7) | (rs2 << 20) | (((u >> 5) & 127) << 25);
            3: return base | (((u >> 11) & 1) << 7) | (((u >> 1) & 15) << 8) | (rs2 << 20)
                      | (((u >> 5) & 63) << 25) | (((u >> 12) & 1) << 31);
            4: return op | (rd << 7) | (u & 32'hFFFF_F000);
            5: return op | (rd << 7) | (((u >> 12) & 255) << 12) | (((u >> 11) & 1) << 20)
                      | (((u >> 1) & 1023) << 21) | (((u >> 20) & 1) << 31);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_check(input int unsigned fmt, f3, input logic [31:0] imm);
        int si;
        bit bad;
        si  = $signed(imm);
        bad = 1'b0;
        if (fmt > 5) return 2;
        case (fmt)
            1: if (f3 == 1 || f3 == 5) bad = (si < 0) || (si > 31);
               else bad = (si < -2048) || (si > 2047);
            2: bad = (si < -2048) || (si > 2047);
            3: bad = (si < -4096) || (si > 4094) || imm[0];
            4: bad = (imm[11:0] != 12'd0);
            5: bad = (si < -1048576) || (si > 1048574) || imm[0];
            default: bad = 1'b0;
        endcase
        return bad ? 1 : 0;
    endfunction

    function automatic void model_reset();
        m_st = ST_IDLE; m_count = 0; m_code = 0; m_addr = BASE; pq.delete();
    endfunction

    function automatic bit model_ready();
        return (m_st == ST_RUN) && (pq.size() == 0 || mem_ready_i);
    endfunction

    // Advance the model by one clock edge using the inputs currently presented.
    function automatic void model_step();
        bit acc, drain;
        int code, st0;
        pw_t e;
        if (!reset) begin model_reset(); return; end
        st0   = m_st;
        acc   = req_valid_i && model_ready();
        drain = (pq.size() > 0) && mem_ready_i;
        code  = 0;
        if (acc) begin
            code = ref_check(fmt_i, funct3_i, imm_i);
            if (code == 0 && m_count + pq.size() == DEPTH) code = 3;
        end
        if (drain) begin
            e = pq.pop_front();
            m_addr += 32'd4;
            if (m_count < 65535) m_count++;
            if (e.last && m_st == ST_RUN) m_st = ST_DONE;
        end
        if (start_i && st0 != ST_RUN) begin
            m_st = ST_RUN; m_addr = BASE; m_count = 0; m_code = 0; pq.delete();
        end
        if (acc) begin
            if (code != 0) begin
                m_st = ST_ERR; m_code = code;
            end else begin
                e.w = ref_encode(fmt_i, opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i);
                e.last = last_i;
                pq.push_back(e);
            end
        end
    endfunction

    // Compare every DUT output with the model once per cycle.
    always @(negedge clk) begin
        chk("req_ready", req_ready_o, model_ready());
        chk("mem_wren", mem_wren_o, pq.size() > 0);
        chk("mem_addr", mem_addr_o, m_addr);
        if (pq.size() > 0) chk("mem_data", mem_data_o, pq[0].w);
        chk("busy", busy_o, m_st == ST_RUN);
        chk("done", done_o, m_st == ST_DONE);
        chk("err", err_o, m_st == ST_ERR);
        chk("err_code", err_code_o, m_code);
        chk("count", count_o, m_count);
    end

    task automatic cyc();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int f, op, f3, f7, rd, rs1, rs2, input logic [31:0] imm, input bit lst);
        req_valid_i = 1'b1; fmt_i = 3'(f); opcode_i = 7'(op); funct3_i = 3'(f3);
        funct7_i = 7'(f7); rd_i = 5'(rd); rs1_i = 5'(rs1); rs2_i = 5'(rs2);
        imm_i = imm; last_i = lst;
    endtask

    task automatic rand_req();
        int f;
        bit bad;
        f = int'($urandom_range(0, 5));
        bad = ($urandom_range(0, 99) < 3);
        set_req(f, int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 32'd0,
                ($urandom_range(0, 24) == 0));
        case (f)
            0: imm_i = $urandom;
            1: if (funct3_i == 3'd1 || funct3_i == 3'd5)
                   imm_i = bad ? 32'd32 : 32'($urandom_range(0, 31));
               else imm_i = bad ? 32'd2048 : 32'($urandom_range(0, 4095)) - 32'd2048;
            2: imm_i = bad ? 32'hFFFF_F7FF : 32'($urandom_range(0, 4095)) - 32'd2048;
            3: imm_i = bad ? 32'd3 : 32'($urandom_range(0, 4095)) * 32'd2 - 32'd4096;
            4: imm_i = bad ? ($urandom | 32'd1) : ($urandom & 32'hFFFF_F000);
            default: imm_i = bad ? 32'h0010_0000
                                 : 32'($urandom_range(0, 1048575)) * 32'd2 - 32'h0010_0000;
        endcase
        if (bad && $urandom_range(0, 1) == 1) fmt_i = 3'd6 + 3'($urandom_range(0, 1));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, req_ready_o, 32'd0);
        chk({tag, "_wren"}, mem_wren_o, 32'd0);
        chk({tag, "_addr"}, mem_addr_o, 32'h0100_0000);
        chk({tag, "_data"}, mem_data_o, 32'd0);
        chk({tag, "_busy"}, busy_o, 32'd0);
        chk({tag, "_done"}, done_o, 32'd0);
        chk({tag, "_err"}, err_o, 32'd0);
        chk({tag, "_code"}, err_code_o, 32'd0);
        chk({tag, "_count"}, count_o, 32'd0);
    endtask

    initial begin
        model_reset();
        chk("pin_add", ref_encode(0, 7'h33, 0, 0, 3, 1, 2, 0), 32'h0020_81B3);
        chk("pin_jal", ref_encode(5, 7'h6F, 0, 0, 1, 0, 0, 32'h800), 32'h0010_00EF);
        repeat (2) @(negedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b1; mem_ready_i = 1'b1;
        cyc();
        start_i = 1'b1; cyc(); start_i = 1'b0;
        chk("busy_after_start", busy_o, 32'd1);

        // Directed program: ADD, ADDI, BEQ, JAL(last).
        set_req(0, 7'h33, 0, 0, 3, 1, 2, 32'd0, 1'b0); cyc();
        chk("add_data", mem_data_o, 32'h0020_81B3);
        chk("add_addr", mem_addr_o, 32'h0100_0000);
        chk("add_wren", mem_wren_o, 32'd1);
        set_req(1, 7'h13, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 1'b0); cyc();
        chk("addi_data", mem_data_o, 32'hFFF0_0093);
        chk("addi_addr", mem_addr_o, 32'h0100_0004);
        set_req(3, 7'h63, 0, 0, 0, 1, 2, 32'd8, 1'b0); cyc();
        chk("beq_data", mem_data_o, 32'h0020_8463);
        chk("count_two", count_o, 32'd2);
        set_req(5, 7'h6F, 0, 0, 1, 0, 0, 32'h800, 1'b1); cyc();
        chk("jal_data", mem_data_o, 32'h0010_00EF);
        req_valid_i = 1'b0; last_i = 1'b0; cyc();
        chk("done_after_last", done_o, 32'd1);
        chk("wren_after_last", mem_wren_o, 32'd0);
        chk("count_four", count_o, 32'd4);

        // Misaligned branch -> error, then restart.
        start_i = 1'b1; cyc(); start_i = 1'b0;
        set_req(3, 7'h63, 0, 0, 0, 1, 2, 32'd3, 1'b0); cyc();
        chk("bimm_err", err_o, 32'd1);
        chk("bimm_code", err_code_o, 32'd1);
        chk("bimm_nowren", mem_wren_o, 32'd0);
        req_valid_i = 1'b0; start_i = 1'b1; cyc(); start_i = 1'b0;
        chk("restart_busy", busy_o, 32'd1);
        chk("restart_err", err_o, 32'd0);
        chk("restart_addr", mem_addr_o, 32'h0100_0000);

        // Backpressure: memory stalls for three cycles with a request waiting.
        set_req(0, 7'h33, 0, 0, 3, 1, 2, 32'd0, 1'b0); cyc();
        mem_ready_i = 1'b0;
        set_req(1, 7'h13, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_ready", req_ready_o, 32'd0);
            chk("bp_data", mem_data_o, 32'h0020_81B3);
            chk("bp_addr", mem_addr_o, 32'h0100_0000);
        end
        mem_ready_i = 1'b1; cyc();
        chk("bp_next_data", mem_data_o, 32'hFFF0_0093);
        chk("bp_next_addr", mem_addr_o, 32'h0100_0004);

        // Depth overflow: keep streaming until the word budget is exhausted.
        for (int i = 0; i < 1100; i++) begin
            set_req(0, int'($urandom_range(0, 127)), 0, 0, 1, 2, 3, 32'd0, 1'b0);
            cyc();
        end
        req_valid_i = 1'b0; cyc(); cyc();
        chk("depth_err", err_o, 32'd1);
        chk("depth_code", err_code_o, 32'd3);
        chk("depth_count", count_o, 32'd1024);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rand_req();
            req_valid_i = ($urandom_range(0, 9) < 7);
            mem_ready_i = ($urandom_range(0, 9) < 7);
            start_i = (m_st != ST_RUN) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            cyc();
        end

        // Asynchronous reset while a write is being held off.
        start_i = 1'b0; req_valid_i = 1'b0;
        reset = 1'b0; cyc(); reset = 1'b1; cyc();
        start_i = 1'b1; cyc(); start_i = 1'b0;
        mem_ready_i = 1'b0;
        set_req(0, 7'h33, 0, 0, 3, 1, 2, 32'd0, 1'b0); cyc();
        chk("pre_reset_wren", mem_wren_o, 32'd1);
        req_valid_i = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1 check_reset_vals("async");
        cyc();
        reset = 1'b1; mem_ready_i = 1'b1;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
